// File: rtl/expression_result_unpacker_if.sv
// expression_result_unpacker_if: packed-vector input and per-field output stream of the unpacker.
interface expression_result_unpacker_if #(
    parameter int OUT_W = 8,
    parameter int SIG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [89:0]      in_y;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [4:0]       out_idx;
    logic             out_last;
    logic [SIG_W-1:0] sig;
    logic             sig_valid;

    modport master (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, sig, sig_valid
    );

    modport slave (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, sig, sig_valid
    );
endinterface

// File: rtl/expression_result_unpacker.sv
// expression_result_unpacker: captures a 90-bit {y0..y17} vector and streams its 18 fields,
// extended to OUT_W, while folding them into a rotate/XOR signature.
module expression_result_unpacker #(
    parameter int OUT_W = 8,
    parameter int SIG_W = 8
) (
    input logic clk,
    input logic rst_n,
    expression_result_unpacker_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_nx;
    logic [89:0]      sh, sh_nx;
    logic [4:0]       idx;
    logic [OUT_W-1:0] data;
    logic             last, fin, cap, acc, sig_valid;
    logic [SIG_W-1:0] run, sig;

    function automatic logic [2:0] width_of(input logic [4:0] i);
        return 3'(4 + i % 3);
    endfunction

    // t is the top six bits of the shift register; the field is its leading w bits
    function automatic logic [OUT_W-1:0] field(input logic [5:0] t, input logic [4:0] i);
        logic [2:0] w;
        logic [5:0] f;
        w = width_of(i);
        f = t >> (3'd6 - w);
        return OUT_W'(f) | ((((i / 3) % 2) != 0 && t[5]) ? {OUT_W{1'b1}} << w : '0);
    endfunction

    always_comb begin
        cap = state == IDLE && !fin && bus.in_valid;
        acc = state == STREAM && bus.out_ready;
        sh_nx = sh << width_of(idx);
        state_nx = cap ? STREAM : (acc && last) ? IDLE : state;
    end

    // fin marks the signature-publish cycle; holding in_ready low there gives the 20-cycle period
    assign bus.in_ready  = state == IDLE && !fin;
    assign bus.out_valid = state == STREAM;
    assign bus.out_data  = data;
    assign bus.out_idx   = idx;
    assign bus.out_last  = last;
    assign bus.sig       = sig;
    assign bus.sig_valid = sig_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh        <= '0;
            idx       <= '0;
            data      <= '0;
            last      <= 1'b0;
            fin       <= 1'b0;
            run       <= '0;
            sig       <= '0;
            sig_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            fin       <= acc && last;
            sig_valid <= fin;
            if (fin)
                sig <= run;
            if (cap) begin
                sh   <= bus.in_y;
                idx  <= '0;
                data <= field(bus.in_y[89:84], 5'd0);
                last <= 1'b0;
                run  <= '0;
            end
            if (acc) begin
                run <= {run[SIG_W-2:0], run[SIG_W-1]} ^ SIG_W'(data);
                if (!last) begin
                    sh   <= sh_nx;
                    idx  <= idx + 5'd1;
                    data <= field(sh_nx[89:84], idx + 5'd1);
                    last <= idx == 5'd16;
                end
            end
        end
    end
endmodule

// File: tb/tb_expression_result_unpacker.sv
// tb_expression_result_unpacker: table-driven vectors plus stall, back-to-back and
// mid-stream reset sequences for the field unpacker.
module tb_expression_result_unpacker;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0, cap_n = 0, cap_last = 0, cap_prev = 0, acc_n = 0;
    logic [7:0] last_sig;

    expression_result_unpacker_if #(.OUT_W(8), .SIG_W(8)) bus ();

    expression_result_unpacker #(.OUT_W(8), .SIG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            cap_n    <= cap_n + 1;
            cap_prev <= cap_last;
            cap_last <= cyc;
        end
        if (rst_n && bus.out_valid && bus.out_ready)
            acc_n <= acc_n + 1;
    end

    typedef struct {
        logic [89:0]      y;
        logic [17:0][7:0] beats;
    } vec_t;

    vec_t tab[4];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [89:0] put(input logic [89:0] y, input int i, input logic [5:0] v);
        int w, p;
        w = 4 + i % 3;
        p = 15 * (i / 3) + ((i % 3 == 0) ? 0 : (i % 3 == 1) ? 4 : 9);
        for (int b = 0; b < w; b++)
            y[89 - p - w + 1 + b] = v[b];
        return y;
    endfunction

    function automatic logic [7:0] sig_of(input logic [17:0][7:0] b);
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < 18; k++)
            s = {s[6:0], s[7]} ^ b[k];
        return s;
    endfunction

    task automatic wait_ready(input string nm);
        int t;
        t = 0;
        while (!bus.in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_vec(input logic [89:0] y, input logic [17:0][7:0] b,
                           input int stall_at, input int stall_len);
        logic [7:0] es;
        es = sig_of(b);
        in_drive(y, 1'b1);
        bus.out_ready = 1'b1;
        wait_ready("ready_before_capture");
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("sig_hold_in_stream", 32'(bus.sig), 32'(last_sig));
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("valid_b%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("data_b%0d", k), 32'(bus.out_data), 32'(b[k]));
            chk($sformatf("idx_b%0d", k), 32'(bus.out_idx), 32'(k));
            chk($sformatf("last_b%0d", k), 32'(bus.out_last), 32'(k == 17));
            if (k == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_data", 32'(bus.out_data), 32'(b[k]));
                    chk("stall_idx", 32'(bus.out_idx), 32'(k));
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("valid_after_last", 32'(bus.out_valid), 32'd0);
        chk("sig_valid_early", 32'(bus.sig_valid), 32'd0);
        @(negedge clk);
        chk("sig_valid_pulse", 32'(bus.sig_valid), 32'd1);
        chk("sig_value", 32'(bus.sig), 32'(es));
        @(negedge clk);
        chk("sig_valid_end", 32'(bus.sig_valid), 32'd0);
        chk("ready_idle", 32'(bus.in_ready), 32'd1);
        last_sig = es;
    endtask

    task automatic in_drive(input logic [89:0] y, input logic v);
        bus.in_y = y;
        bus.in_valid = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic sv_seen;
        int   t;
        for (int i = 0; i < 4; i++) begin
            tab[i].y = '0;
            tab[i].beats = '0;
        end
        tab[1].y = put(put(90'd0, 0, 6'h0F), 3, 6'h08);
        tab[1].beats[0] = 8'h0F;
        tab[1].beats[3] = 8'hF8;
        tab[2].y = '1;
        for (int k = 0; k < 18; k++)
            tab[2].beats[k] = ((k / 3) % 2 == 1) ? 8'hFF :
                              (k % 3 == 0) ? 8'h0F : (k % 3 == 1) ? 8'h1F : 8'h3F;
        tab[3].y = put(put(put(put(put(90'd0, 1, 6'h10), 4, 6'h10), 5, 6'h1F), 14, 6'h3F), 17, 6'h21);
        tab[3].beats[1]  = 8'h10;
        tab[3].beats[4]  = 8'hF0;
        tab[3].beats[5]  = 8'h1F;
        tab[3].beats[14] = 8'h3F;
        tab[3].beats[17] = 8'hE1;

        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        in_drive('1, 1'b1);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_sig", 32'(bus.sig), 32'd0);
        chk("rst_sig_valid", 32'(bus.sig_valid), 32'd0);
        rst_n = 1'b1;
        last_sig = '0;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_vec(tab[i].y, tab[i].beats, -1, 0);

        t = acc_n;
        run_vec(tab[2].y, tab[2].beats, 7, 5);
        chk("stall_total_beats", 32'(acc_n - t), 32'd18);

        bus.out_ready = 1'b1;
        in_drive(tab[3].y, 1'b1);
        t = cap_n;
        wait_ready("b2b_ready");
        @(posedge clk);
        @(negedge clk);
        chk("b2b_first_capture", 32'(cap_n - t), 32'd1);
        bus.in_y = tab[2].y;
        t = 0;
        while (!(bus.out_valid && bus.out_idx == 5'd0 && cap_n >= 2 && bus.out_data == tab[2].beats[0]) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_period", 32'(cap_last - cap_prev), 32'd20);
        chk("b2b_second_idx", 32'(bus.out_idx), 32'd0);
        chk("b2b_second_data", 32'(bus.out_data), 32'(tab[2].beats[0]));
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.sig_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_sig", 32'(bus.sig), 32'(sig_of(tab[2].beats)));
        last_sig = sig_of(tab[2].beats);
        @(negedge clk);

        in_drive(tab[2].y, 1'b1);
        wait_ready("rst_mid_ready");
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("rst_mid_at_beat9", 32'(bus.out_idx), 32'd9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_data", 32'(bus.out_data), 32'd0);
        chk("rst_mid_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_mid_last", 32'(bus.out_last), 32'd0);
        chk("rst_mid_sig", 32'(bus.sig), 32'd0);
        chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
        sv_seen = 1'b0;
        repeat (25) begin
            sv_seen |= bus.sig_valid;
            @(negedge clk);
        end
        chk("rst_mid_no_sig_valid", 32'(sv_seen), 32'd0);
        last_sig = '0;
        run_vec(tab[3].y, tab[3].beats, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
